// File: rtl/edid_i2c_responder.sv
// EDID/DDC I2C target at I2C_ADDR serving a host-loaded 256x8 image; SDA is open-drain (sda_oe pulls low).
// Edges seen SYNC_STAGES clk after the pads; define EDID_I2C_GLITCH_FILTER_EN for a FILTER_LEN-clk line filter.
module edid_i2c_responder #(
   parameter logic [6:0] I2C_ADDR    = 7'h50,
   parameter int         SYNC_STAGES = 2,
   parameter int         FILTER_LEN  = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   input  logic       edid_wr_en,
   input  logic [7:0] edid_wr_addr,
   input  logic [7:0] edid_wr_data,
   output logic       busy,
   output logic       xfer_done,
   output logic [7:0] rd_ptr
);

   if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
      $error("edid_i2c_responder: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
   end

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, WORD, WORD_ACK, WR_DATA, RD_DATA, RD_ACK, WAIT_STOP
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic scl_c, sda_c, scl_q, sda_q;
   logic scl_rise, scl_fall, start_det, stop_det;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      end
   end

`ifdef EDID_I2C_GLITCH_FILTER_EN
   localparam int FCW = $clog2(FILTER_LEN + 1);
   logic [FCW-1:0] scl_cnt, sda_cnt;
   logic           scl_flt, sda_flt;

   // A line only follows its input after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_flt <= 1'b1;
         sda_flt <= 1'b1;
         scl_cnt <= '0;
         sda_cnt <= '0;
      end else begin
         if (scl_sync[SYNC_STAGES-1] == scl_flt) begin
            scl_cnt <= '0;
         end else if (scl_cnt == FCW'(FILTER_LEN - 1)) begin
            scl_flt <= scl_sync[SYNC_STAGES-1];
            scl_cnt <= '0;
         end else begin
            scl_cnt <= scl_cnt + FCW'(1);
         end
         if (sda_sync[SYNC_STAGES-1] == sda_flt) begin
            sda_cnt <= '0;
         end else if (sda_cnt == FCW'(FILTER_LEN - 1)) begin
            sda_flt <= sda_sync[SYNC_STAGES-1];
            sda_cnt <= '0;
         end else begin
            sda_cnt <= sda_cnt + FCW'(1);
         end
      end
   end

   assign scl_c = scl_flt;
   assign sda_c = sda_flt;
`else
   assign scl_c = scl_sync[SYNC_STAGES-1];
   assign sda_c = sda_sync[SYNC_STAGES-1];
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_q <= scl_c;
         sda_q <= sda_c;
      end
   end

   assign scl_rise  = scl_c & ~scl_q;
   assign scl_fall  = ~scl_c & scl_q;
   assign start_det = scl_c & scl_q & sda_q & ~sda_c;
   assign stop_det  = scl_c & scl_q & ~sda_q & sda_c;

   logic [7:0] mem [256];
   logic [7:0] load_byte;

   always_ff @(posedge clk) begin
      if (edid_wr_en) mem[edid_wr_addr] <= edid_wr_data;
   end

   // Write-first: a same-cycle host write to the byte being loaded wins.
   assign load_byte = (edid_wr_en && edid_wr_addr == rd_ptr) ? edid_wr_data : mem[rd_ptr];

   state_t     state, state_nx;
   logic [3:0] bit_cnt, cnt_nx;
   logic [7:0] shift, shift_nx, ptr_nx, rx_byte;
   logic       oe_nx, matched, matched_nx, is_read, rd_nx, done_nx;

   assign rx_byte = {shift[6:0], sda_c};
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift     <= '0;
         sda_oe    <= 1'b0;
         rd_ptr    <= '0;
         matched   <= 1'b0;
         is_read   <= 1'b0;
         xfer_done <= 1'b0;
      end else begin
         state     <= state_nx;
         bit_cnt   <= cnt_nx;
         shift     <= shift_nx;
         sda_oe    <= oe_nx;
         rd_ptr    <= ptr_nx;
         matched   <= matched_nx;
         is_read   <= rd_nx;
         xfer_done <= done_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = bit_cnt;
      shift_nx   = shift;
      oe_nx      = sda_oe;
      ptr_nx     = rd_ptr;
      matched_nx = matched;
      rd_nx      = is_read;
      done_nx    = 1'b0;
      if (stop_det) begin
         state_nx   = IDLE;
         oe_nx      = 1'b0;
         cnt_nx     = '0;
         done_nx    = matched;
         matched_nx = 1'b0;
      end else if (start_det) begin
         state_nx = ADDR;
         oe_nx    = 1'b0;
         cnt_nx   = '0;
      end else begin
         case (state)
            ADDR, WORD, WR_DATA: begin
               if (scl_rise) begin
                  shift_nx = rx_byte;
                  cnt_nx   = bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     cnt_nx = '0;
                     if (state == ADDR) begin
                        if (rx_byte[7:1] == I2C_ADDR) begin
                           state_nx   = ADDR_ACK;
                           matched_nx = 1'b1;
                           rd_nx      = rx_byte[0];
                        end else begin
                           state_nx = IDLE;
                        end
                     end else begin
                        if (state == WORD) ptr_nx = rx_byte;
                        state_nx = WORD_ACK;
                     end
                  end
               end
            end
            // First fall after the 8th bit asserts ACK; the next fall ends the 9th clock.
            ADDR_ACK, WORD_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe) begin
                     oe_nx = 1'b1;
                  end else if (state == ADDR_ACK && is_read) begin
                     shift_nx = load_byte;
                     oe_nx    = ~load_byte[7];
                     state_nx = RD_DATA;
                  end else begin
                     oe_nx    = 1'b0;
                     state_nx = (state == ADDR_ACK) ? WORD : WR_DATA;
                  end
               end
            end
            RD_DATA: begin
               if (scl_rise) begin
                  cnt_nx = bit_cnt + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     oe_nx    = 1'b0;
                     ptr_nx   = rd_ptr + 8'd1;
                     cnt_nx   = '0;
                     state_nx = RD_ACK;
                  end else begin
                     shift_nx = {shift[6:0], 1'b0};
                     oe_nx    = ~shift[6];
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  if (sda_c) state_nx = WAIT_STOP;
                  else       cnt_nx   = 4'd1;
               end else if (scl_fall && bit_cnt == 4'd1) begin
                  shift_nx = load_byte;
                  oe_nx    = ~load_byte[7];
                  cnt_nx   = '0;
                  state_nx = RD_DATA;
               end
            end
            IDLE, WAIT_STOP: ;
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule
